icache_refill_engine: RTL and testbench
=======================================

Name: icache_refill_engine

Overview:
- Memory-side responder for the direct-mapped instruction cache.
- On a miss request it fetches the four 32-bit words of the missed line from instruction memory, one word per memory handshake.
- It assembles the words into a 128-bit line, then presents the line and its address to the cache for a single cycle so the cache can install it.
- It sits between the fetch-stage cache and the instruction memory, and drives the front-end stall through `busy`.

Parameters:
- ADDR_WIDTH, 32, byte address width of the miss and memory addresses.
- WORD_WIDTH, 32, memory word and instruction width.
- LINE_WORDS, 4, words per line. Fixed at 4; the line is 128 bits and offset bits [3:2] select the word.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- miss_req  input  1  cache miss; the requester holds it high until `busy` is seen high.
- miss_address  input  32  faulting fetch address; sampled only on acceptance.
- abort  input  1  flush request (branch redirect); cancels the current refill.
- mem_read  output  1  memory read request.
- mem_addr  output  32  word-aligned memory address.
- mem_rdata  input  32  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory beat complete.
- line_data  output  128  assembled line; word k is in bits [32k+31:32k].
- line_address  output  32  line base address, {miss_address[31:4], 4'b0}.
- line_valid  output  1  one-cycle strobe: line_data and line_address are valid for installation.
- busy  output  1  high whenever state is not IDLE; stalls fetch.

Behaviour:
- Reset is synchronous and active-high and has priority over all other inputs.
  - Reset forces state to IDLE.
  - mem_read=0, mem_addr=0, line_data=0, line_address=0, line_valid=0, busy=0.
  - beat counter=0, abort flag=0.
  - Reset asserted mid-refill drops the refill silently; no line_valid is produced.
- States: IDLE, FETCH, DONE, HOLD.
- IDLE:
  - When miss_req=1, latch base = {miss_address[31:4], 4'b0} into line_address, clear the beat counter, and go to FETCH.
  - If miss_req and abort are both high, abort wins: stay in IDLE.
- FETCH:
  - mem_read=1 and mem_addr = line_address + 4*beat, both registered and held stable until mem_ready=1.
  - On a cycle with mem_ready=1:
    - mem_rdata is written into word slot `beat`.
    - The beat counter increments.
    - At the new beat, mem_addr advances on the next cycle.
  - After beat 3 completes, go to DONE with mem_read=0.
  - Beats complete in order 0,1,2,3. The beat counter is 2 bits and never wraps within a refill.
- abort during FETCH:
  - A request already issued cannot be withdrawn. Set the abort flag and keep mem_read high until mem_ready=1.
  - The returned data is discarded, and the state then goes to IDLE with mem_read=0 and no line_valid.
  - If abort and mem_ready arrive in the same cycle, that beat ends the refill and the next state is IDLE.
  - abort in DONE or HOLD is ignored; the line is still delivered.
- DONE: line_valid=1 for exactly one cycle, with line_data and line_address stable. Go to HOLD.
- HOLD:
  - One cycle during which miss_req is ignored. This covers the cache's registered hit lookup on the freshly installed line.
  - Go to IDLE.
- line_data and line_address keep their last values after DONE. They are only overwritten by the next accepted miss.
- miss_address changes after acceptance have no effect.
- Latency with mem_ready tied high:
  - Miss accepted at edge 0.
  - Beats complete at edges 1–4.
  - line_valid is high in cycle 5.
  - HOLD in cycle 6.
  - IDLE, able to accept a new miss, in cycle 7.
- Each memory wait cycle adds one cycle of latency.
- mem_addr[1:0] is always 0.

Test Plan:
- Reset, then miss_req with miss_address=0x0000_0128, mem_ready=1 always:
  - mem_addr sequence is 0x120, 0x124, 0x128, 0x12C.
  - Memory returns 0xA0, 0xA1, 0xA2, 0xA3.
  - line_valid is high for exactly one cycle, in cycle 5.
  - line_address=0x0000_0120 and line_data=0x000000A3_000000A2_000000A1_000000A0.
- Same miss with mem_ready low for 2 cycles on every beat:
  - mem_addr and mem_read are held stable during each wait.
  - line_valid is seen in cycle 13.
  - line_data is the same as in the first scenario.
- abort asserted while beat 1 is waiting (mem_ready=0):
  - mem_read stays high until mem_ready=1, then drops.
  - State returns to IDLE.
  - line_valid never rises and line_data keeps its previous value.
- miss_req held high through DONE and HOLD with a new miss_address=0x0000_0400:
  - The second refill starts only in IDLE (cycle 7).
  - The next mem_addr is 0x400.
- Reset pulsed in the cycle beat 2 completes:
  - Next cycle mem_read=0, busy=0, line_data=0.
  - No line_valid is produced.
  - A subsequent miss refills normally.

Source files
------------

// File: rtl/icache_refill_engine.sv
// Purpose: fetches a missed 4-word instruction line from memory and hands it to the cache.
// Latency: with mem_ready held high, line_valid comes 5 cycles after acceptance; idle again 2 cycles later.
// Backpressure: mem_read/mem_addr are held until mem_ready; busy stalls fetch for the whole refill.
module icache_refill_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             miss_req,
  input  logic [ADDR_WIDTH-1:0]            miss_address,
  input  logic                             abort,
  output logic                             mem_read,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] line_data,
  output logic [ADDR_WIDTH-1:0]            line_address,
  output logic                             line_valid,
  output logic                             busy
);

  localparam int LINE_WIDTH = WORD_WIDTH * LINE_WORDS;
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, HOLD} state_t;

  state_t                  state;
  logic [1:0]              beat;
  logic                    abort_flag;
  // Words land here first so an aborted refill never disturbs the last delivered line.
  logic [LINE_WIDTH-1:0]   line_buf;
  logic [ADDR_WIDTH-1:0]   base;
  logic                    addr_offset_unused;

  assign base               = {miss_address[ADDR_WIDTH-1:4], 4'b0};
  assign addr_offset_unused = ^miss_address[3:0];

  // Refill sequencer: accept miss, run four in-order beats, strobe the line, then one guard cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= 2'd0;
      abort_flag   <= 1'b0;
      line_buf     <= '0;
      mem_read     <= 1'b0;
      mem_addr     <= '0;
      line_data    <= '0;
      line_address <= '0;
      line_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A redirect in the same cycle as the miss makes the miss stale.
          if (miss_req && !abort) begin
            state        <= FETCH;
            line_address <= base;
            mem_addr     <= base;
            mem_read     <= 1'b1;
            beat         <= 2'd0;
            abort_flag   <= 1'b0;
            busy         <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            if (abort || abort_flag) begin
              // The outstanding beat has now retired; drop its data and the refill.
              state      <= IDLE;
              mem_read   <= 1'b0;
              abort_flag <= 1'b0;
              busy       <= 1'b0;
            end else if (beat == 2'd3) begin
              state      <= DONE;
              mem_read   <= 1'b0;
              line_data  <= {mem_rdata, line_buf[LINE_WIDTH-WORD_WIDTH-1:0]};
              line_valid <= 1'b1;
            end else begin
              line_buf[beat*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
              beat     <= beat + 2'd1;
              mem_addr <= mem_addr + WORD_BYTES;
            end
          end else if (abort) begin
            // Memory request cannot be withdrawn; remember to discard it when it completes.
            abort_flag <= 1'b1;
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          // Gives the cache's registered lookup a cycle to see the new line before another miss.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Bench for icache_refill_engine: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_icache_refill_engine;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_address = 32'h0;
  logic         abort = 1'b0;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = 32'h0;
  logic         mem_ready = 1'b0;
  logic [127:0] line_data;
  logic [31:0]  line_address;
  logic         line_valid;
  logic         busy;

  icache_refill_engine dut (
    .clock(clock), .reset(reset), .miss_req(miss_req), .miss_address(miss_address),
    .abort(abort), .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .line_data(line_data), .line_address(line_address),
    .line_valid(line_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: one refill transaction at a time.
  bit           m_active   = 0;
  bit           m_aborting = 0;
  int           m_beats    = 0;
  int           m_post     = 0;   // 2: line strobe cycle, 1: guard cycle, 0: none
  logic [31:0]  m_base     = 0;
  logic [31:0]  m_line_addr = 0;
  logic [127:0] m_line_data = 0;
  logic [31:0]  m_words[4];

  int           rdy_mode = 0;
  int           waits    = 0;
  int           wait_n   = 0;
  int           e        = 0;
  int           lv_seen  = 0;
  logic [31:0]  hs_q[$];

  localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h12) return 32'hA0 + {30'h0, a[3:2]};
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_active = 0; m_aborting = 0; m_beats = 0; m_post = 0;
      m_base = 0; m_line_addr = 0; m_line_data = 0;
    end else if (m_post == 2) begin
      m_post = 1;
    end else if (m_post == 1) begin
      m_post = 0;
    end else if (!m_active) begin
      if (miss_req && !abort) begin
        m_active = 1; m_aborting = 0; m_beats = 0;
        m_base = miss_address & ~32'hF;
        m_line_addr = m_base;
      end
    end else begin
      if (abort) m_aborting = 1;
      if (mem_ready) begin
        if (m_aborting) begin
          m_active = 0;
        end else begin
          m_words[m_beats[1:0]] = mem_rdata;
          m_beats++;
          if (m_beats == 4) begin
            m_active = 0;
            m_line_data = {m_words[3], m_words[2], m_words[1], m_words[0]};
            m_post = 2;
          end
        end
      end
    end
  endtask

  task automatic compare();
    chk("busy", busy, m_active || m_post != 0);
    chk("mem_read", mem_read, m_active);
    chk("line_valid", line_valid, m_post == 2);
    chk("line_data", line_data, m_line_data);
    chk("line_address", line_address, m_line_addr);
    if (m_active) chk("mem_addr", mem_addr, m_base + 32'(4 * m_beats));
    chk("mem_addr_align", mem_addr[1:0], 0);
  endtask

  // Memory responder: data is a function of address, ready after `waits` idle cycles per beat.
  task automatic drive_mem();
    if (mem_read) begin
      mem_rdata = mem_word(mem_addr);
      if (wait_n >= waits) begin
        mem_ready = 1'b1;
        wait_n = 0;
        if (rdy_mode == 2) waits = $urandom_range(0, 3);
      end else begin
        mem_ready = 1'b0;
        wait_n++;
      end
    end else begin
      wait_n = 0;
      mem_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    if (mem_read && mem_ready && !reset) hs_q.push_back(mem_addr);
    @(posedge clock);
    model_edge();
    #1;
    compare();
    if (line_valid) lv_seen++;
    drive_mem();
    e++;
  endtask

  task automatic start_miss(input logic [31:0] addr);
    miss_req = 1'b1;
    miss_address = addr;
    step();
    e = 0;
    miss_req = 1'b0;
  endtask

  task automatic run_until_idle(input int max, output int lv_cycle, output int idle_cycle);
    lv_cycle = -1;
    idle_cycle = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (line_valid && lv_cycle < 0) lv_cycle = e + 1;
      if (!busy) begin
        idle_cycle = e + 1;
        break;
      end
    end
  endtask

  initial begin
    int lv, idle, start2, lv_before, lv_rand;
    logic [31:0] addr2;
    logic pr;

    // Reset
    step(); step();
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_line_data", line_data, 0);
    chk("reset_line_valid", line_valid, 0);

    // Scenario 1: zero-wait refill of 0x128
    rdy_mode = 0; waits = 0;
    hs_q.delete();
    start_miss(32'h0000_0128);
    run_until_idle(20, lv, idle);
    chk("s1_lv_cycle", lv, 5);
    chk("s1_idle_cycle", idle, 7);
    chk("s1_beats", hs_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("s1_mem_addr_seq", (i < hs_q.size()) ? hs_q[i] : 32'hFFFF_FFFF, 32'h120 + 32'(4 * i));
    chk("s1_line_address", line_address, 32'h0000_0120);
    chk("s1_line_data", line_data, LINE_A);

    // Scenario 2: two wait cycles per beat
    rdy_mode = 1; waits = 2;
    start_miss(32'h0000_0128);
    run_until_idle(40, lv, idle);
    chk("s2_lv_cycle", lv, 13);
    chk("s2_line_data", line_data, LINE_A);

    // Scenario 3: abort while beat 1 waits
    start_miss(32'h0000_0128);
    step(); step(); step();
    chk("s3_waiting_addr", mem_addr, 32'h124);
    lv_before = lv_seen;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s3_read_held_a", mem_read, 1);
    step();
    chk("s3_read_held_b", mem_read, 1);
    step();
    chk("s3_read_dropped", mem_read, 0);
    chk("s3_idle", busy, 0);
    repeat (4) step();
    chk("s3_no_line_valid", lv_seen - lv_before, 0);
    chk("s3_line_data_kept", line_data, LINE_A);

    // Scenario 4: miss_req held through DONE/HOLD with new address
    rdy_mode = 0; waits = 0;
    miss_req = 1'b1;
    miss_address = 32'h0000_0128;
    step();
    e = 0;
    miss_address = 32'h0000_0400;
    start2 = -1;
    addr2 = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      pr = mem_read;
      step();
      if (line_valid) chk("s4_first_line_address", line_address, 32'h120);
      if (mem_read && !pr) begin
        start2 = e;
        addr2 = mem_addr;
        break;
      end
    end
    miss_req = 1'b0;
    chk("s4_second_start", start2, 7);
    chk("s4_second_addr", addr2, 32'h400);
    e = 0;
    run_until_idle(20, lv, idle);
    chk("s4_second_lv", lv, 5);
    chk("s4_second_line_address", line_address, 32'h400);

    // Scenario 5: reset on the edge where beat 2 completes
    start_miss(32'h0000_0128);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5_mem_read", mem_read, 0);
    chk("s5_busy", busy, 0);
    chk("s5_line_data", line_data, 0);
    lv_before = lv_seen;
    repeat (5) step();
    chk("s5_no_line_valid", lv_seen - lv_before, 0);
    start_miss(32'h0000_0128);
    run_until_idle(20, lv, idle);
    chk("s5_refill_lv", lv, 5);
    chk("s5_refill_data", line_data, LINE_A);

    // Randomized soak
    rdy_mode = 2; waits = 1;
    lv_before = lv_seen;
    for (int i = 0; i < 3000; i++) begin
      miss_req = ($urandom_range(0, 2) != 0);
      miss_address = $urandom;
      abort = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; miss_req = 1'b0; abort = 1'b0;
    repeat (30) step();
    lv_rand = lv_seen - lv_before;
    chk("rand_lines_delivered", lv_rand > 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
